// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared state encoding and helpers for the round-robin arbiter
//
// Purpose: holds the arbiter FSM state type and a constant-foldable ceil(log2)
// helper. The helper is used to size the grant index and the hold counter.
// Ports: none (package).
package arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // ceil(log2(value)); clog2(1) == 0, clog2(2) == 1, clog2(5) == 3.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arbiter_rr_prio_pick.sv
// rtl/arbiter_rr_prio_pick.sv - lowest-index picker over a masked request vector
//
// Purpose: combinational priority pick of the lowest-index bit set in req & mask.
// Ports:
//   req    [N-1:0]   request vector
//   mask   [N-1:0]   eligibility mask (1 = may win)
//   onehot [N-1:0]   one-hot winner, zero when nothing eligible
//   idx    [IDW-1:0] winner index, zero when nothing eligible
//   found            high when an eligible request exists
module arb_prio_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           found
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    // Scan downward so the lowest eligible index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && mask[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDW'(i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbiter_rr.sv
// rtl/arbiter_rr.sv - N-way round-robin / fixed-priority arbiter with hold limit
//
// Purpose: registered one-hot grant among N requesters. mode=0 round-robin from
// ptr, mode=1 fixed priority (index 0 highest). A holder keeps the grant while
// it requests, up to MAX_HOLD cycles when others are waiting (0 = unlimited).
// Ports:
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   mode              0 = round-robin, 1 = fixed priority
//   req    [N-1:0]    request vector
//   gnt    [N-1:0]    registered one-hot grant
//   gnt_valid         high while a grant is held
//   gnt_id [IDW-1:0]  index of the granted requester, 0 when idle
module arbiter_rr
  import arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id
);

  // Counter keeps at least one bit so MAX_HOLD=0 still elaborates.
  localparam int CW_RAW = clog2(MAX_HOLD + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CNT_MAX = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [N-1:0]   cand;
  logic [N-1:0]   above_mask;
  logic [N-1:0]   all_mask;
  logic [N-1:0]   m_onehot, f_onehot, win_onehot;
  logic [IDW-1:0] m_idx, f_idx, win_idx, ptr_next;
  logic           m_found, f_found, win_found;
  logic           holder_req, limit_hit;

  // The current holder never competes in its own re-arbitration: either it has
  // dropped its request or it is being forced off by the hold limit.
  always_comb begin
    cand     = (state_q == GRANT) ? (req & ~gnt_q) : req;
    all_mask = '1;
    for (int i = 0; i < N; i++) begin
      above_mask[i] = (IDW'(i) >= ptr_q);
    end
  end

  arb_prio_pick #(.N(N), .IDW(IDW)) u_pick_masked (
    .req    (cand),
    .mask   (above_mask),
    .onehot (m_onehot),
    .idx    (m_idx),
    .found  (m_found)
  );

  arb_prio_pick #(.N(N), .IDW(IDW)) u_pick_fallback (
    .req    (cand),
    .mask   (all_mask),
    .onehot (f_onehot),
    .idx    (f_idx),
    .found  (f_found)
  );

  always_comb begin
    // Round-robin wraps to the unmasked search when nothing sits at/above ptr.
    if (!mode && m_found) begin
      win_onehot = m_onehot;
      win_idx    = m_idx;
    end else begin
      win_onehot = f_onehot;
      win_idx    = f_idx;
    end
    win_found  = f_found;
    ptr_next   = (win_idx == IDW'(N - 1)) ? '0 : win_idx + 1'b1;
    holder_req = |(req & gnt_q);
    limit_hit  = (MAX_HOLD != 0) && (cnt_q == CNT_MAX);

    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (win_found) begin
          state_d     = GRANT;
          gnt_d       = win_onehot;
          gnt_valid_d = 1'b1;
          gnt_id_d    = win_idx;
          ptr_d       = ptr_next;
        end
      end
      GRANT: begin
        if (holder_req && !(limit_hit && win_found)) begin
          // Holding: count up, saturating at the limit when nobody else waits.
          if (MAX_HOLD != 0 && !limit_hit) cnt_d = cnt_q + 1'b1;
        end else if (win_found) begin
          gnt_d       = win_onehot;
          gnt_valid_d = 1'b1;
          gnt_id_d    = win_idx;
          ptr_d       = ptr_next;
          cnt_d       = '0;
        end else begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_id_d    = '0;
          cnt_d       = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
        cnt_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_arbiter_rr.sv
// tb/tb_arbiter_rr.sv - self-checking bench for arbiter_rr (N=4, MAX_HOLD=4)
module tb_arbiter_rr;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int IDW      = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           mode;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;

  always #5 clk = ~clk;

  arbiter_rr #(.N(N), .MAX_HOLD(MAX_HOLD), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who holds the grant, where the round-robin search starts,
  // and how many cycles the holder has kept it.
  int m_holder = -1;
  int m_ptr    = 0;
  int m_cnt    = 0;

  typedef struct {
    logic       rst;
    logic       mode;
    logic [3:0] req;
    logic [3:0] exp_gnt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic m, input logic [N-1:0] rq);
    bit others;
    int w;
    int idx;
    if (r) begin
      m_holder = -1;
      m_ptr    = 0;
      m_cnt    = 0;
      return;
    end
    others = 0;
    for (int i = 0; i < N; i++) if (rq[i] && i != m_holder) others = 1;
    if (m_holder >= 0 && rq[m_holder] && !(m_cnt == MAX_HOLD - 1 && others)) begin
      if (m_cnt < MAX_HOLD - 1) m_cnt++;
    end else begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = m ? k : (m_ptr + k) % N;
        if (w < 0 && rq[idx] && idx != m_holder) w = idx;
      end
      if (w < 0) begin
        m_holder = -1;
      end else begin
        m_holder = w;
        m_ptr    = (w + 1) % N;
      end
      m_cnt = 0;
    end
  endtask

  task automatic cycle(input logic r, input logic m, input logic [N-1:0] rq);
    logic [N-1:0] exp_gnt;
    rst  = r;
    mode = m;
    req  = rq;
    @(posedge clk);
    model_step(r, m, rq);
    #1;
    exp_gnt = (m_holder < 0) ? '0 : N'(1 << m_holder);
    check("gnt_vs_model", gnt, exp_gnt);
    check("gnt_valid_vs_model", gnt_valid, (m_holder >= 0) ? 1 : 0);
    check("gnt_id_vs_model", gnt_id, (m_holder < 0) ? 0 : m_holder);
    check("gnt_onehot0", $onehot0(gnt), 1);
  endtask

  task automatic add(input logic r, input logic m, input logic [3:0] rq, input logic [3:0] eg);
    vec_t v;
    v.rst = r; v.mode = m; v.req = rq; v.exp_gnt = eg;
    tbl.push_back(v);
  endtask

  initial begin
    rst  = 1'b1;
    mode = 1'b0;
    req  = '0;

    // Reset held with all requests pending, then first grant goes to index 0.
    add(1, 0, 4'b1111, 4'b0000);
    add(1, 0, 4'b1111, 4'b0000);
    add(1, 0, 4'b1111, 4'b0000);
    add(0, 0, 4'b1111, 4'b0001);
    // Round-robin rotation: each holder drops for one cycle.
    add(0, 0, 4'b1110, 4'b0010);
    add(0, 0, 4'b1101, 4'b0100);
    add(0, 0, 4'b1011, 4'b1000);
    add(0, 0, 4'b0111, 4'b0001);
    // Fixed priority.
    add(0, 1, 4'b1010, 4'b0010);
    add(0, 1, 4'b1000, 4'b1000);
    add(0, 1, 4'b0000, 4'b0000);
    // Hold limit: req0 alone, then req2 joins; four cycles of 0001 in total.
    add(0, 0, 4'b0001, 4'b0001);
    add(0, 0, 4'b0101, 4'b0001);
    add(0, 0, 4'b0101, 4'b0001);
    add(0, 0, 4'b0101, 4'b0001);
    add(0, 0, 4'b0101, 4'b0100);
    add(0, 0, 4'b0001, 4'b0001);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].mode, tbl[i].req);
      check($sformatf("table_row%0d_gnt", i), gnt, tbl[i].exp_gnt);
    end

    // Saturation: lone holder keeps the grant, counter pins at MAX_HOLD-1.
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 4'b0001);
      check("saturate_gnt", gnt, 4'b0001);
    end
    check("saturate_cnt", dut.cnt_q, 3);

    // Mid-grant reset.
    cycle(0, 0, 4'b0100);
    check("midrst_pre_gnt", gnt, 4'b0100);
    cycle(0, 0, 4'b0100);
    check("midrst_hold_gnt", gnt, 4'b0100);
    cycle(1, 0, 4'b0100);
    check("midrst_rst_gnt", gnt, 4'b0000);
    check("midrst_rst_id", gnt_id, 0);
    cycle(0, 0, 4'b0100);
    check("midrst_return_gnt", gnt, 4'b0100);

    // Randomized traffic against the model; requests are sticky-ish so holders
    // both run into the hold limit and release.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] rq;
      logic         rr;
      logic         mm;
      rq = N'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0 && m_holder >= 0) rq[m_holder] = 1'b1;
      rr = ($urandom_range(0, 40) == 0);
      mm = ($urandom_range(0, 7) == 0) ? ~mode : mode;
      cycle(rr, mm, rq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
